// File: rtl/crc_ccitt_frame_checker_if.sv
// Byte-stream bundle between the receive deframer and the CRC-CCITT frame checker.
// Latency: none, this is wiring only.
// Backpressure: none, the checker consumes every valid byte.
//
// Ports (slave view, i.e. the checker):
//   in_valid    in   a frame byte is present this cycle
//   in_data     in   frame byte, bit 7 first on the wire
//   in_last     in   qualifies in_valid: final CRC byte (low byte) of the frame
//   abort       in   discard the frame in progress
//   busy        out  a frame is in progress
//   done        out  one-cycle pulse when the result outputs update
//   crc_ok      out  last frame had zero residue and a legal length
//   len_err     out  last frame was shorter than the minimum length
//   frame_len   out  byte count of last frame (saturating)
//   crc_residue out  final CRC register of last frame
interface crc_ccitt_frame_checker_if;
   logic        in_valid;
   logic [7:0]  in_data;
   logic        in_last;
   logic        abort;
   logic        busy;
   logic        done;
   logic        crc_ok;
   logic        len_err;
   logic [15:0] frame_len;
   logic [15:0] crc_residue;

   // Source side: deframer / testbench drives bytes and observes results.
   modport master (
      output in_valid,
      output in_data,
      output in_last,
      output abort,
      input  busy,
      input  done,
      input  crc_ok,
      input  len_err,
      input  frame_len,
      input  crc_residue
   );

   // Checker side.
   modport slave (
      input  in_valid,
      input  in_data,
      input  in_last,
      input  abort,
      output busy,
      output done,
      output crc_ok,
      output len_err,
      output frame_len,
      output crc_residue
   );
endinterface

// File: rtl/crc_ccitt_frame_checker.sv
// Receive-side CRC-CCITT (0x1021, MSB-first) frame checker, one byte per cycle.
// Latency: result and done pulse appear the cycle after the in_last byte is sampled.
// Backpressure: none; always ready, every in_valid cycle consumes a byte.
//
// Ports:
//   i_clk    rising-edge clock
//   i_rst_n  asynchronous active-low reset
//   io_bus   crc_ccitt_frame_checker_if.slave (byte stream in, results out)
//
// Parameters:
//   INIT     CRC preset loaded at the start of every frame
//   MIN_LEN  minimum legal frame length in bytes, CRC bytes included
//
// The received CRC bytes are folded into the running CRC, so an intact frame
// leaves a residue of zero. Frame length counts every accepted byte of the
// frame including the two CRC bytes.
module crc_ccitt_frame_checker #(
   parameter logic [15:0] INIT    = 16'hFFFF,
   parameter logic [15:0] MIN_LEN = 16'd3
) (
   input  logic                        i_clk,
   input  logic                        i_rst_n,
   crc_ccitt_frame_checker_if.slave    io_bus
);

   localparam logic [15:0] POLY = 16'h1021;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_BODY = 1'b1
   } state_t;

   // ---------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------
   state_t      r_state;
   state_t      w_state_nxt;

   logic [15:0] r_crc;
   logic [15:0] r_cnt;

   logic        r_done;
   logic        r_crc_ok;
   logic        r_len_err;
   logic [15:0] r_frame_len;
   logic [15:0] r_crc_residue;

   // FSM control strobes
   logic        w_update;   // fold this byte into the running CRC/count
   logic        w_result;   // frame ends with this byte: publish results
   logic        w_reload;   // re-seed CRC/count for the next frame

   // Datapath
   logic [15:0] w_crc_nxt;
   logic [15:0] w_cnt_nxt;
   logic        w_len_err;
   logic        w_crc_ok;

   // ---------------------------------------------------------------------
   // Eight MSB-first LFSR steps unrolled into one combinational stage.
   // Data bit 7 is shifted in first.
   // ---------------------------------------------------------------------
   function automatic logic [15:0] crc8_step(input logic [15:0] crc,
                                             input logic [7:0]  dat);
      logic [15:0] c;
      c = crc;
      for (int i = 7; i >= 0; i--) begin
         if (c[15] ^ dat[i]) begin
            c = {c[14:0], 1'b0} ^ POLY;
         end else begin
            c = {c[14:0], 1'b0};
         end
      end
      return c;
   endfunction

   assign w_crc_nxt = crc8_step(r_crc, io_bus.in_data);

   // Count saturates; the CRC keeps running past saturation.
   assign w_cnt_nxt = (r_cnt == 16'hFFFF) ? r_cnt : (r_cnt + 16'd1);

   assign w_len_err = (w_cnt_nxt < MIN_LEN);
   assign w_crc_ok  = (w_crc_nxt == 16'h0000) && !w_len_err;

   // ---------------------------------------------------------------------
   // FSM state register
   // ---------------------------------------------------------------------
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // ---------------------------------------------------------------------
   // FSM next state and control strobes.
   // abort wins over in_valid in the same cycle: the byte is dropped and
   // nothing is reported. In IDLE there is nothing to discard, so abort
   // merely suppresses the byte.
   // ---------------------------------------------------------------------
   always_comb begin
      w_state_nxt = r_state;
      w_update    = 1'b0;
      w_result    = 1'b0;
      w_reload    = 1'b0;

      case (r_state)
         S_IDLE: begin
            if (io_bus.in_valid && !io_bus.abort) begin
               if (io_bus.in_last) begin
                  // Single-byte frame: reported immediately, always len_err.
                  w_result = 1'b1;
                  w_reload = 1'b1;
               end else begin
                  w_update    = 1'b1;
                  w_state_nxt = S_BODY;
               end
            end
         end

         S_BODY: begin
            if (io_bus.abort) begin
               w_reload    = 1'b1;
               w_state_nxt = S_IDLE;
            end else if (io_bus.in_valid) begin
               if (io_bus.in_last) begin
                  w_result    = 1'b1;
                  w_reload    = 1'b1;
                  w_state_nxt = S_IDLE;
               end else begin
                  w_update = 1'b1;
               end
            end
         end

         default: begin
            w_state_nxt = S_IDLE;
            w_reload    = 1'b1;
         end
      endcase
   end

   // ---------------------------------------------------------------------
   // Running CRC and byte count. Reload takes priority so that the frame
   // following an in_last (possibly the very next cycle) starts from INIT.
   // ---------------------------------------------------------------------
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_crc <= INIT;
         r_cnt <= 16'h0000;
      end else if (w_reload) begin
         r_crc <= INIT;
         r_cnt <= 16'h0000;
      end else if (w_update) begin
         r_crc <= w_crc_nxt;
         r_cnt <= w_cnt_nxt;
      end
   end

   // ---------------------------------------------------------------------
   // Result registers: updated only on a reported frame end, held otherwise
   // (an aborted frame leaves the previous result visible).
   // ---------------------------------------------------------------------
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_done        <= 1'b0;
         r_crc_ok      <= 1'b0;
         r_len_err     <= 1'b0;
         r_frame_len   <= 16'h0000;
         r_crc_residue <= INIT;
      end else begin
         r_done <= w_result;
         if (w_result) begin
            r_crc_ok      <= w_crc_ok;
            r_len_err     <= w_len_err;
            r_frame_len   <= w_cnt_nxt;
            r_crc_residue <= w_crc_nxt;
         end
      end
   end

   // ---------------------------------------------------------------------
   // Outputs: all driven straight from flops.
   // ---------------------------------------------------------------------
   assign io_bus.busy        = (r_state == S_BODY);
   assign io_bus.done        = r_done;
   assign io_bus.crc_ok      = r_crc_ok;
   assign io_bus.len_err     = r_len_err;
   assign io_bus.frame_len   = r_frame_len;
   assign io_bus.crc_residue = r_crc_residue;

endmodule

// File: tb/tb_crc_ccitt_frame_checker.sv
// Testbench for crc_ccitt_frame_checker: two instances (INIT=FFFF and INIT=0000)
// receive the same byte stream; results are compared against a frame-level
// CRC model computed from the polynomial definition.
module tb_crc_ccitt_frame_checker;

   typedef logic [7:0] bytes_t[$];

   logic clk = 1'b0;
   logic rst_n;

   always #5 clk = ~clk;

   crc_ccitt_frame_checker_if bus_a ();
   crc_ccitt_frame_checker_if bus_b ();

   crc_ccitt_frame_checker #(
      .INIT    (16'hFFFF),
      .MIN_LEN (16'd3)
   ) u_dut_a (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .io_bus  (bus_a.slave)
   );

   crc_ccitt_frame_checker #(
      .INIT    (16'h0000),
      .MIN_LEN (16'd3)
   ) u_dut_b (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .io_bus  (bus_b.slave)
   );

   int checks     = 0;
   int errors     = 0;
   int done_cnt_a = 0;
   int done_cnt_b = 0;
   int exp_done   = 0;

   // Count every done pulse seen, sampled away from the active edge.
   always @(negedge clk) begin
      if (bus_a.done === 1'b1) done_cnt_a++;
      if (bus_b.done === 1'b1) done_cnt_b++;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Drive one cycle of input to both instances, then sample 1 time unit
   // after the edge that consumed it.
   task automatic step(input logic v, input logic [7:0] d, input logic l, input logic a);
      bus_a.in_valid = v; bus_a.in_data = d; bus_a.in_last = l; bus_a.abort = a;
      bus_b.in_valid = v; bus_b.in_data = d; bus_b.in_last = l; bus_b.abort = a;
      @(posedge clk);
      #1;
   endtask

   // CRC over a whole byte sequence by polynomial division, MSB-first.
   function automatic logic [15:0] ref_crc(input logic [15:0] init, input bytes_t q);
      int r;
      r = int'(init);
      foreach (q[k]) begin
         for (int b = 7; b >= 0; b--) begin
            int msb;
            int bit_v;
            msb   = (r >> 15) & 1;
            bit_v = (int'(q[k]) >> b) & 1;
            r     = (r << 1) & 32'hFFFF;
            if (msb != bit_v) r = r ^ 32'h1021;
         end
      end
      return r[15:0];
   endfunction

   task automatic check_reset_vals(input string tag);
      chk({tag, "_busy_a"},  bus_a.busy,        0);
      chk({tag, "_done_a"},  bus_a.done,        0);
      chk({tag, "_ok_a"},    bus_a.crc_ok,      0);
      chk({tag, "_lerr_a"},  bus_a.len_err,     0);
      chk({tag, "_len_a"},   bus_a.frame_len,   0);
      chk({tag, "_res_a"},   bus_a.crc_residue, 32'hFFFF);
      chk({tag, "_busy_b"},  bus_b.busy,        0);
      chk({tag, "_done_b"},  bus_b.done,        0);
      chk({tag, "_res_b"},   bus_b.crc_residue, 32'h0000);
   endtask

   // Compare both instances against the model for a completed frame.
   task automatic check_result(input string tag, input bytes_t f);
      logic [15:0] ra;
      logic [15:0] rb;
      int          len;
      logic        le;
      len = f.size();
      le  = (len < 3);
      ra  = ref_crc(16'hFFFF, f);
      rb  = ref_crc(16'h0000, f);
      exp_done++;
      chk({tag, "_done_a"}, bus_a.done,        1);
      chk({tag, "_res_a"},  bus_a.crc_residue, {16'h0, ra});
      chk({tag, "_len_a"},  bus_a.frame_len,   len);
      chk({tag, "_lerr_a"}, bus_a.len_err,     {31'h0, le});
      chk({tag, "_ok_a"},   bus_a.crc_ok,      {31'h0, (ra == 16'h0) && !le});
      chk({tag, "_done_b"}, bus_b.done,        1);
      chk({tag, "_res_b"},  bus_b.crc_residue, {16'h0, rb});
      chk({tag, "_len_b"},  bus_b.frame_len,   len);
      chk({tag, "_lerr_b"}, bus_b.len_err,     {31'h0, le});
      chk({tag, "_ok_b"},   bus_b.crc_ok,      {31'h0, (rb == 16'h0) && !le});
   endtask

   // Send a frame with up to max_gap idle cycles between bytes. With b2b the
   // task returns in the done cycle so the next frame follows with no gap.
   task automatic send_frame(input string tag, input bytes_t f, input int max_gap, input bit b2b);
      for (int i = 0; i < f.size(); i++) begin
         if (max_gap > 0 && i > 0) begin
            int g;
            g = $urandom_range(0, max_gap);
            repeat (g) step(1'b0, 8'h00, 1'b0, 1'b0);
         end
         step(1'b1, f[i], (i == f.size() - 1), 1'b0);
         if (i == 0 && f.size() > 1) chk({tag, "_busy_up"}, bus_a.busy, 1);
      end
      check_result(tag, f);
      if (!b2b) begin
         step(1'b0, 8'h00, 1'b0, 1'b0);
         chk({tag, "_done_pulse"}, bus_a.done, 0);
         chk({tag, "_busy_dn"},    bus_a.busy, 0);
      end
   endtask

   initial begin
      bytes_t      pay;
      bytes_t      good_a;
      bytes_t      bad_a;
      bytes_t      good_b;
      bytes_t      tiny;
      bytes_t      one;
      bytes_t      f3;
      bytes_t      rnd;
      logic [15:0] c;

      pay    = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
      good_a = {pay, 8'h29, 8'hB1};
      bad_a  = {pay, 8'h29, 8'hB0};
      good_b = {pay, 8'h31, 8'hC3};
      tiny   = '{8'h00, 8'h00};
      one    = '{8'hA5};

      rst_n = 1'b0;
      bus_a.in_valid = 1'b0; bus_a.in_data = 8'h00; bus_a.in_last = 1'b0; bus_a.abort = 1'b0;
      bus_b.in_valid = 1'b0; bus_b.in_data = 8'h00; bus_b.in_last = 1'b0; bus_b.abort = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_reset_vals("rst");
      rst_n = 1'b1;
      step(1'b0, 8'h00, 1'b0, 1'b0);

      // Known-good CCITT-FALSE frame.
      send_frame("tp1", good_a, 0, 1'b0);
      chk("tp1_ok_const",  bus_a.crc_ok,      1);
      chk("tp1_len_const", bus_a.frame_len,   11);
      chk("tp1_res_const", bus_a.crc_residue, 0);

      // Corrupted frame, then the good one back-to-back.
      send_frame("tp2_bad", bad_a, 0, 1'b1);
      chk("tp2_ok_const", bus_a.crc_ok, 0);
      chk("tp2_res_nz",   {31'h0, bus_a.crc_residue != 16'h0}, 1);
      send_frame("tp2_good", good_a, 0, 1'b0);
      chk("tp2_good_ok", bus_a.crc_ok, 1);

      // XMODEM-style frame for the INIT=0000 instance, then a short frame.
      send_frame("tp3", good_b, 0, 1'b0);
      chk("tp3_ok_b_const", bus_b.crc_ok, 1);
      send_frame("tp3_short", tiny, 0, 1'b0);
      chk("tp3_short_lerr", bus_b.len_err,   1);
      chk("tp3_short_ok",   bus_b.crc_ok,    0);
      chk("tp3_short_len",  bus_b.frame_len, 2);

      // Exactly MIN_LEN bytes: legal and correct for the INIT=FFFF instance.
      c  = ref_crc(16'hFFFF, '{8'h41});
      f3 = '{8'h41, c[15:8], c[7:0]};
      send_frame("min_len", f3, 0, 1'b0);
      chk("min_len_ok",   bus_a.crc_ok,  1);
      chk("min_len_lerr", bus_a.len_err, 0);

      // Single-byte frame straight from IDLE.
      send_frame("one", one, 0, 1'b0);
      chk("one_len",  bus_a.frame_len, 1);
      chk("one_lerr", bus_a.len_err,   1);

      // Abort mid-frame: no result, previous result held, busy drops.
      step(1'b1, 8'h31, 1'b0, 1'b0);
      step(1'b1, 8'h32, 1'b0, 1'b0);
      step(1'b1, 8'h33, 1'b0, 1'b0);
      chk("abort_busy_pre", bus_a.busy, 1);
      step(1'b1, 8'h34, 1'b0, 1'b1);
      chk("abort_busy",      bus_a.busy,      0);
      chk("abort_done",      bus_a.done,      0);
      chk("abort_hold_len",  bus_a.frame_len, 1);
      chk("abort_hold_lerr", bus_a.len_err,   1);
      // Abort in IDLE together with a last byte: byte dropped, no report.
      step(1'b1, 8'h55, 1'b1, 1'b1);
      chk("abort_idle_done", bus_a.done, 0);
      chk("abort_idle_busy", bus_a.busy, 0);
      send_frame("after_abort", good_a, 0, 1'b0);
      chk("after_abort_len", bus_a.frame_len, 11);
      chk("after_abort_ok",  bus_a.crc_ok,    1);

      // Same good frame with random idle gaps.
      for (int k = 0; k < 3; k++) begin
         send_frame("gaps", good_a, 5, 1'b0);
         chk("gaps_ok_const", bus_a.crc_ok, 1);
      end

      // Random frames: valid or corrupted for the INIT=FFFF instance,
      // random gaps and random back-to-back chaining.
      for (int k = 0; k < 8; k++) begin
         int n;
         n = $urandom_range(1, 20);
         rnd = {};
         for (int i = 0; i < n; i++) rnd.push_back(8'($urandom_range(0, 255)));
         c = ref_crc(16'hFFFF, rnd);
         rnd.push_back(c[15:8]);
         rnd.push_back(c[7:0]);
         if ($urandom_range(0, 2) == 0) rnd[0] = rnd[0] ^ 8'h01;
         send_frame("rnd", rnd, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
      end
      step(1'b0, 8'h00, 1'b0, 1'b0);

      // Reset dropped after 4 bytes of a frame.
      for (int i = 0; i < 4; i++) step(1'b1, good_a[i], 1'b0, 1'b0);
      chk("midrst_busy_pre", bus_a.busy, 1);
      rst_n = 1'b0;
      #1;
      check_reset_vals("midrst");
      step(1'b0, 8'h00, 1'b0, 1'b0);
      step(1'b0, 8'h00, 1'b0, 1'b0);
      check_reset_vals("midrst_hold");
      rst_n = 1'b1;
      step(1'b0, 8'h00, 1'b0, 1'b0);
      send_frame("post_rst", good_a, 0, 1'b0);
      chk("post_rst_ok",  bus_a.crc_ok,    1);
      chk("post_rst_len", bus_a.frame_len, 11);

      step(1'b0, 8'h00, 1'b0, 1'b0);
      chk("done_count_a", done_cnt_a, exp_done);
      chk("done_count_b", done_cnt_b, exp_done);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/crc_ccitt_frame_checker.md
# crc_ccitt_frame_checker

Receive-side companion to the serial CRC-CCITT generator. It consumes a byte stream framed as payload followed by the 2-byte CRC, high byte first. It recomputes CRC-CCITT over the whole frame in one cycle per byte and reports pass/fail, frame length and the residue. It sits after the byte deframer in the receive path and feeds the frame-accept logic.

## Interface
- INIT, 16'hFFFF, CRC preset loaded at the start of every frame.
- MIN_LEN, 3, minimum legal frame length in bytes, CRC bytes included.
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- in_valid  input  1  in_data is a frame byte this cycle.
- in_data  input  8  frame byte; bit 7 is processed first.
- in_last  input  1  qualifies in_valid; this byte is the final CRC byte (low byte).
- abort  input  1  discard the frame in progress.
- busy  output  1  a frame is in progress (at least one byte accepted, no in_last yet).
- done  output  1  one-cycle pulse: the result outputs are updated.
- crc_ok  output  1  last frame's residue was 16'h0000 and its length was legal.
- len_err  output  1  last frame was shorter than MIN_LEN bytes.
- frame_len  output  16  byte count of last frame; saturates at 16'hFFFF.
- crc_residue  output  16  final CRC register of last frame.

## Operation
- Polynomial 0x1021, MSB-first, non-reflected, no output XOR. The next-CRC for 8 bits is unrolled combinationally, giving one byte per cycle.
- Because the received CRC is folded into the computation, a correct frame leaves residue 16'h0000.
- The block is always ready. No back-pressure exists; every cycle with in_valid=1 consumes a byte.
- FSM states:
  - IDLE: CRC register = INIT, count = 0.
  - IDLE → BODY: in_valid & !in_last & !abort.
  - IDLE → IDLE with result: in_valid & in_last. This is a 1-byte frame, reported with len_err=1.
  - BODY: updates the CRC and count on each in_valid.
  - BODY → IDLE with result: in_valid & in_last.
  - BODY → IDLE without result: abort.
- On the result transition:
  - crc_residue = CRC after the last byte.
  - frame_len = count including the last byte.
  - len_err = (frame_len < MIN_LEN).
  - crc_ok = (residue == 0) & !len_err.
  - The CRC register and count reload INIT/0 for the next frame.
- abort has priority over in_valid in the same cycle. That byte is dropped and nothing is reported. abort in IDLE has no effect.
- The count saturates at 16'hFFFF; the CRC continues to update past saturation.
- Result outputs hold until the next result. Abort does not clear them.

## Timing
- Reset values: busy=0, done=0, crc_ok=0, len_err=0, frame_len=16'h0000, crc_residue=INIT. Internal state: FSM=IDLE, CRC=INIT, count=0.
- Reset asserted mid-frame discards the frame immediately. No done pulse is produced.
- Latency: a byte with in_last sampled at edge N produces done=1 and updated results in the cycle after edge N. done is high for exactly one cycle.
- busy rises the cycle after the first byte is accepted. It falls the cycle after the in_last byte or abort is sampled.
- Back-to-back frames are allowed. The first byte of frame k+1 may arrive in the cycle immediately after the in_last of frame k (the cycle where done is high), with no idle gap.
- Gaps (in_valid=0) inside a frame are allowed and hold all state.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- INIT=16'hFFFF. Send "123456789" (31..39), then 29, then B1 with in_last → one done pulse, crc_ok=1, len_err=0, frame_len=11, crc_residue=0000.
- Same frame with the final byte B0 → crc_ok=0, crc_residue≠0000, frame_len=11. Then send the correct frame immediately after, with no gap → second done pulse with crc_ok=1.
- INIT=16'h0000 instance. Send "123456789" + 31 + C3 → crc_ok=1. Then send 2-byte frame 00, 00 → len_err=1, crc_ok=0, frame_len=2.
- Send 31 32 33, then assert abort together with in_valid → no done. busy=0 next cycle. The following valid frame passes with frame_len=11, proving the CRC was re-seeded.
- Valid frame with random in_valid gaps (up to 5 idle cycles between bytes) → result identical to the gap-free case.
- Drop reset to 0 after 4 bytes of a frame → all outputs at reset values, no done. After release, a full valid frame gives crc_ok=1, frame_len=11.
